// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port working-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int DEFAULT_MEM_DEPTH = 32513;
    localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view,
// master = requesters plus the memory array.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req0, lock0, we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0, rvalid0, err0;
    logic [DATA_W-1:0] rdata0;

    logic              req1, lock1, we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1, rvalid1, err1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, lock0, we0, addr0, wdata0,
        input  req1, lock1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, err0, rdata0,
        output gnt1, rvalid1, err1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, lock0, we0, addr0, wdata0,
        output req1, lock1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, err0, rdata0,
        input  gnt1, rvalid1, err1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin grant logic with bounded burst locking. Grants are combinational
// from req and the registered owner state so an access completes in its grant cycle.
module rr_lock_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic lock0,
    input  logic req1,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    owner_state_t     state_reg, state_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic             last_gnt_reg, last_gnt_next;

    logic [1:0] req, lock, gnt;
    logic       win, win_valid, hold, own, oth;

    assign req  = {req1, req0};
    assign lock = {lock1, lock0};
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    always_comb begin
        gnt            = 2'b00;
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        last_gnt_next  = last_gnt_reg;
        win            = 1'b0;
        win_valid      = 1'b0;
        hold           = 1'b0;
        own            = (state_reg == OWN1);
        oth            = ~own;

        if (state_reg == IDLE) begin
            win_valid = |req;
            win       = (req == 2'b11) ? ~last_gnt_reg : req[1];
        end else if (!req[own]) begin
            win_valid = req[oth];
            win       = oth;
        end else if (burst_cnt_reg == MAX_CNT && req[oth]) begin
            // Burst budget spent while the other port waits: forced handoff.
            win_valid = 1'b1;
            win       = oth;
        end else begin
            win_valid = 1'b1;
            win       = own;
            hold      = 1'b1;
        end

        if (win_valid) begin
            gnt[win]      = 1'b1;
            last_gnt_next = win;
            if (hold && lock[win]) begin
                burst_cnt_next = (burst_cnt_reg == MAX_CNT) ? burst_cnt_reg : burst_cnt_reg + 1'b1;
            end else if (!hold && lock[win]) begin
                state_next     = win ? OWN1 : OWN0;
                burst_cnt_next = CNT_W'(1);
            end else begin
                state_next     = IDLE;
                burst_cnt_next = '0;
            end
        end else begin
            state_next     = IDLE;
            burst_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            last_gnt_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            last_gnt_reg  <= last_gnt_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port working memory between the CPU port and the loader DMA
// port: command mux, range check and tagged 1-cycle read-return routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    logic [1:0]        we, gnt, rvalid, err;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [DATA_W-1:0] rdata [2];

    logic              grant_any, win_id, in_range;
    logic [ADDR_W-1:0] sel_addr;

    logic rd_ok_reg, rd_oor_reg, err_reg, id_reg;

    assign we       = {bus.we1, bus.we0};
    assign addr[0]  = bus.addr0;
    assign addr[1]  = bus.addr1;
    assign wdata[0] = bus.wdata0;
    assign wdata[1] = bus.wdata1;

    rr_lock_arbiter #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req0  (bus.req0),
        .lock0 (bus.lock0),
        .req1  (bus.req1),
        .lock1 (bus.lock1),
        .gnt0  (gnt[0]),
        .gnt1  (gnt[1])
    );

    assign grant_any = |gnt;
    assign win_id    = gnt[PORT_LDR];
    assign sel_addr  = addr[win_id];
    assign in_range  = {1'b0, sel_addr} < DEPTH_L;

    // Out-of-range accesses are still granted but never reach the array.
    assign bus.mem_en    = grant_any && in_range;
    assign bus.mem_we    = grant_any && in_range && we[win_id];
    assign bus.mem_addr  = grant_any ? sel_addr : '0;
    assign bus.mem_wdata = grant_any ? wdata[win_id] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ok_reg  <= 1'b0;
            rd_oor_reg <= 1'b0;
            err_reg    <= 1'b0;
            id_reg     <= PORT_CPU;
        end else begin
            rd_ok_reg  <= grant_any && in_range && !we[win_id];
            rd_oor_reg <= grant_any && !in_range && !we[win_id];
            err_reg    <= grant_any && !in_range;
            id_reg     <= win_id;
        end
    end

    // The registered winner id steers the return so alternating grants route correctly.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        assign rvalid[gi] = (rd_ok_reg || rd_oor_reg) && (id_reg == 1'(gi));
        assign err[gi]    = err_reg && (id_reg == 1'(gi));
        assign rdata[gi]  = (rd_ok_reg && (id_reg == 1'(gi))) ? bus.mem_rdata : '0;
    end

    assign bus.gnt0    = gnt[0];
    assign bus.gnt1    = gnt[1];
    assign bus.rvalid0 = rvalid[0];
    assign bus.rvalid1 = rvalid[1];
    assign bus.err0    = err[0];
    assign bus.err1    = err[1];
    assign bus.rdata0  = rdata[0];
    assign bus.rdata1  = rdata[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random stimulus for mem_port_arbiter, checked against a
// transaction-level model of ownership, round-robin order and memory contents.
module tb_mem_port_arbiter;
    localparam int MEM_DEPTH = 32513;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus();

    mem_port_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (8),
        .MEM_DEPTH (MEM_DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory array seen by the DUT, with a side door for preloading.
    bit   [7:0]  env_mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) env_mem[pre_addr] <= pre_data;
        else if (bus.mem_en) begin
            if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= env_mem[bus.mem_addr];
        end
    end

    // Reference model state.
    bit [7:0] ref_mem [0:65535];
    int m_owner, m_streak, m_last;
    int checks = 0;
    int errors = 0;
    int last_g;

    bit          cur_v  [2];
    bit          cur_we [2];
    bit          cur_lk [2];
    logic [15:0] cur_addr [2];
    logic [7:0]  cur_wd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.req0 = cur_v[0]; bus.lock0 = cur_lk[0]; bus.we0 = cur_we[0];
        bus.addr0 = cur_addr[0]; bus.wdata0 = cur_wd[0];
        bus.req1 = cur_v[1]; bus.lock1 = cur_lk[1]; bus.we1 = cur_we[1];
        bus.addr1 = cur_addr[1]; bus.wdata1 = cur_wd[1];
    endtask

    // One clock: check the grant-cycle command, then the returns after the edge.
    task automatic tick();
        int g, o;
        bit rq [2];
        bit lk [2];
        bit w, inr, was_rst_low;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic [1:0]  exp_rv, exp_er;
        logic [7:0]  exp_rd [2];
        #1;
        rq[0] = bus.req0; rq[1] = bus.req1;
        lk[0] = bus.lock0; lk[1] = bus.lock1;
        g = -1;
        if (m_owner < 0) begin
            if (rq[0] && rq[1]) g = 1 - m_last;
            else if (rq[0])     g = 0;
            else if (rq[1])     g = 1;
        end else begin
            o = m_owner;
            if (!rq[o])                                  g = rq[1-o] ? 1 - o : -1;
            else if (m_streak >= MAX_BURST && rq[1-o])  g = 1 - o;
            else                                         g = o;
        end
        wa  = (g == 1) ? bus.addr1 : bus.addr0;
        wd  = (g == 1) ? bus.wdata1 : bus.wdata0;
        w   = (g == 1) ? bus.we1 : bus.we0;
        inr = (g >= 0) && (int'(wa) < MEM_DEPTH);

        chk("gnt0", bus.gnt0, g == 0);
        chk("gnt1", bus.gnt1, g == 1);
        chk("mem_en", bus.mem_en, inr);
        chk("mem_we", bus.mem_we, inr && w);
        if (g >= 0) chk("mem_addr", bus.mem_addr, wa);
        if (g >= 0 && w) chk("mem_wdata", bus.mem_wdata, wd);

        exp_rv = '0; exp_er = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        if (g >= 0) begin
            exp_er[g] = !inr;
            exp_rv[g] = !w;
            exp_rd[g] = (!w && inr) ? ref_mem[wa] : 8'h00;
            if (inr && w) ref_mem[wa] = wd;
            m_last = g;
            if (!lk[g])             begin m_owner = -1; m_streak = 0; end
            else if (g == m_owner)  m_streak = (m_streak < MAX_BURST) ? m_streak + 1 : MAX_BURST;
            else                    begin m_owner = g; m_streak = 1; end
        end else begin
            m_owner = -1; m_streak = 0;
        end
        was_rst_low = !rst;

        @(posedge clk);
        #1;
        if (was_rst_low) begin
            m_owner = -1; m_streak = 0; m_last = 1;
            exp_rv = '0; exp_er = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        end
        chk("rvalid0", bus.rvalid0, exp_rv[0]);
        chk("rvalid1", bus.rvalid1, exp_rv[1]);
        chk("err0", bus.err0, exp_er[0]);
        chk("err1", bus.err1, exp_er[1]);
        chk("rdata0", bus.rdata0, exp_rd[0]);
        chk("rdata1", bus.rdata1, exp_rd[1]);
        last_g = g;
    endtask

    task automatic run_cycle();
        apply();
        tick();
        if (last_g >= 0) begin
            $display("txn port%0d %s addr=%04h data=%02h lock=%0d rst=%0d", last_g,
                     cur_we[last_g] ? "WR" : "RD", cur_addr[last_g],
                     cur_we[last_g] ? cur_wd[last_g] : 8'h00, cur_lk[last_g], rst);
            cur_v[last_g] = 1'b0;
        end
    endtask

    task automatic set_txn(input int p, input bit w, input logic [15:0] a,
                           input logic [7:0] d, input bit l);
        cur_v[p] = 1'b1; cur_we[p] = w; cur_addr[p] = a; cur_wd[p] = d; cur_lk[p] = l;
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6)      return 16'($urandom_range(0, 31));
        else if (r < 9) return 16'($urandom_range(32505, 32520));
        else            return 16'($urandom);
    endfunction

    initial begin
        int bexp [7];
        int writes_left;
        bexp = '{0, 0, 0, 0, 1, 0, 0};
        m_owner = -1; m_streak = 0; m_last = 1;
        for (int p = 0; p < 2; p++) begin
            cur_v[p] = 0; cur_we[p] = 0; cur_lk[p] = 0; cur_addr[p] = '0; cur_wd[p] = '0;
        end
        rst = 1'b0;
        apply();

        // Preload while in reset.
        for (int i = 0; i < 6; i++) begin
            pre_addr = (i == 0) ? 16'h0010 : 16'($urandom_range(0, 31));
            if (i != 0 && pre_addr == 16'h0010) pre_addr = 16'h0011;
            pre_data = (i == 0) ? 8'hA5 : 8'($urandom);
            pre_we   = 1'b1;
            ref_mem[pre_addr] = pre_data;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_gnt0", bus.gnt0, 0);     chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_mem_en", bus.mem_en, 0); chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0); chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_rvalid0", bus.rvalid0, 0); chk("rst_rvalid1", bus.rvalid1, 0);
        chk("rst_err0", bus.err0, 0);     chk("rst_err1", bus.err1, 0);
        chk("rst_rdata0", bus.rdata0, 0); chk("rst_rdata1", bus.rdata1, 0);

        // Single CPU read of a preloaded byte.
        rst = 1'b1;
        set_txn(0, 0, 16'h0010, 8'h00, 0);
        run_cycle();
        chk("rd10_winner", last_g, 0);
        chk("rd10_rvalid0", bus.rvalid0, 1);
        chk("rd10_rdata0", bus.rdata0, 8'hA5);

        // Loader read granted in the cycle whose edge applies reset: return discarded.
        set_txn(1, 0, 16'h0010, 8'h00, 0);
        rst = 1'b0;
        run_cycle();
        chk("inflight_winner", last_g, 1);
        chk("inflight_rvalid1", bus.rvalid1, 0);
        run_cycle();
        rst = 1'b1;

        // Both ports continuously requesting reads: strict alternation from port 0.
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 2; p++)
                if (!cur_v[p]) set_txn(p, 0, 16'($urandom_range(0, 31)), 8'h00, 0);
            run_cycle();
            chk("alt_winner", last_g, i % 2);
        end

        // Locked burst of six writes on port 0 against a waiting port 1.
        writes_left = 6;
        set_txn(0, 1, 16'h0020, 8'($urandom), 1);
        set_txn(1, 0, 16'h0010, 8'h00, 0);
        for (int i = 0; i < 7; i++) begin
            if (!cur_v[0] && writes_left > 0)
                set_txn(0, 1, 16'(16'h0020 + 6 - writes_left), 8'($urandom), 1);
            if (!cur_v[1]) set_txn(1, 0, 16'($urandom_range(0, 31)), 8'h00, 0);
            run_cycle();
            chk("burst_winner", last_g, bexp[i]);
            if (last_g == 0) writes_left--;
        end
        cur_v[0] = 0; cur_lk[0] = 0;

        // Out-of-range write and read on the loader port, then the last valid byte.
        set_txn(1, 1, 16'h7F01, 8'h3C, 0);
        run_cycle();
        chk("oor_wr_winner", last_g, 1);
        chk("oor_wr_err1", bus.err1, 1);
        chk("oor_wr_mem", env_mem[16'h7F01], 8'h00);
        set_txn(1, 0, 16'h7F01, 8'h00, 0);
        run_cycle();
        chk("oor_rd_rvalid1", bus.rvalid1, 1);
        chk("oor_rd_rdata1", bus.rdata1, 8'h00);
        chk("oor_rd_err1", bus.err1, 1);
        set_txn(1, 1, 16'h7F00, 8'h5A, 0);
        run_cycle();
        set_txn(1, 0, 16'h7F00, 8'h00, 0);
        run_cycle();
        chk("edge_rd_rdata1", bus.rdata1, 8'h5A);
        chk("edge_rd_err1", bus.err1, 0);

        // Locked owner drops its request: the other port wins in the same cycle.
        set_txn(0, 1, 16'h0005, 8'h77, 1);
        run_cycle();
        chk("lockdrop_own", last_g, 0);
        set_txn(1, 0, 16'h0005, 8'h00, 1);
        run_cycle();
        chk("lockdrop_handoff", last_g, 1);
        set_txn(0, 0, 16'h0006, 8'h00, 0);
        set_txn(1, 0, 16'h0007, 8'h00, 1);
        run_cycle();
        chk("lockdrop_own1", last_g, 1);
        cur_lk[1] = 0;

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!cur_v[p] && $urandom_range(0, 2) != 0)
                    set_txn(p, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), 0);
                cur_lk[p] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 63) != 0);
            run_cycle();
        end
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the processor's single-port working memory between the CPU load/store/fetch port (port 0) and a host/boot-loader DMA port (port 1).
- Sits between the requesters and the memory array.
- Round-robin arbitration with optional bounded burst locking.
- Handles range checking, 1-cycle read-data return routing and error signalling.

Parameters:
- ADDR_W, 16, requester/memory address width
- DATA_W, 8, data width
- MEM_DEPTH, 32513, number of implemented bytes; addresses >= MEM_DEPTH are out of range
- MAX_BURST, 4, maximum consecutive grants to one locked owner while the other port is requesting (>= 1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- req0  in  1  port 0 (CPU) access request
- lock0  in  1  port 0 requests to keep ownership for subsequent accesses
- we0  in  1  port 0 write enable (1 = write, 0 = read)
- addr0  in  ADDR_W  port 0 byte address
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  port 0 access accepted this cycle
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_W  port 0 read data
- err0  out  1  port 0 out-of-range access response
- req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1: same as port 0, for port 1 (loader)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read strobe

Behaviour:
- Reset (rst=0 at a clock edge):
  - owner state -> IDLE, burst_cnt -> 0, last_gnt -> 1 (port 0 wins the first tie).
  - Pending read and error flags are cleared.
  - All gnt/rvalid/err = 0, all rdata = 0.
  - mem_en/mem_we = 0, mem_addr/mem_wdata = 0.
  - Any read in flight at reset is discarded; no rvalid follows.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - gnt is combinational from req and the registered state, so an access completes in the grant cycle.
  - At most one gnt is high per cycle; gnt never asserts without its req.
- Memory command:
  - In a grant cycle, mem_addr/mem_wdata/mem_we are muxed from the winner.
  - mem_en = 1 only if addr < MEM_DEPTH.
  - In non-grant cycles mem_en = mem_we = 0.
- Read return (latency 1):
  - The cycle after a granted in-range read, the winner sees rvalid = 1 and rdata = mem_rdata.
  - rdata is 0 whenever rvalid = 0.
- Out-of-range access: still granted; mem_en = 0 and writes are dropped.
  - Next cycle: err = 1 for one cycle.
  - If it was a read, rvalid = 1 and rdata = 0 in that same cycle.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE:
    - Only one req: grant it.
    - Both req: grant port != last_gnt.
    - If the winner has lock asserted, go to OWNx with burst_cnt = 1; otherwise stay IDLE and update last_gnt.
  - OWNx:
    - reqx is given priority while lockx = 1 and (burst_cnt < MAX_BURST or the other req = 0); burst_cnt increments, saturating at MAX_BURST.
    - lockx = 0 releases to IDLE after the current grant.
    - reqx = 0 releases to IDLE in that cycle, and the other port may be granted in the same cycle.
    - burst_cnt == MAX_BURST with the other req = 1: forced handoff. The other port is granted this cycle, last_gnt is updated, and the state goes to OWN(other) if its lock = 1, else IDLE.
- last_gnt is updated on every grant.
- Back-to-back grants to alternating ports are allowed every cycle; read returns are tagged with a registered winner id so routing is correct.

Decomposition:
- Shared package mem_arb_pkg holds:
  - owner-state enum (IDLE/OWN0/OWN1)
  - port-id constants PORT_CPU = 0, PORT_LDR = 1
  - default MEM_DEPTH
- Natural sub-module: rr_lock_arbiter. It holds the FSM, last_gnt and burst_cnt, and outputs gnt0/gnt1.
- The top level contains the datapath mux, range check and read-return tagging.

Test Plan:
- Reset release, then req0 read addr 0x0010 (mem holds 0xA5) -> gnt0 same cycle, mem_en = 1, mem_addr = 0x0010; next cycle rvalid0 = 1, rdata0 = 0xA5; rvalid1 = 0.
- req0 and req1 both held continuously, no lock, reads -> grants alternate 0,1,0,1 every cycle, starting with port 0; each rvalid is routed to the correct port.
- req0 + lock0 held with 6 queued writes, req1 held, MAX_BURST = 4 -> gnt0 for 4 cycles, gnt1 on the 5th, then gnt0 resumes.
- req1 write addr 0x7F01 (>= 32513), data 0x3C -> gnt1 = 1, mem_en = 0; next cycle err1 = 1; memory unchanged. Then a req1 read of the same address -> rvalid1 = 1, rdata1 = 0x00, err1 = 1.
- Granted read on port 1, then rst = 0 on the next edge -> no rvalid1 after reset; all outputs 0; first post-reset tie is won by port 0.
- Port 0 locked in OWN0 drops req0 while req1 = 1 -> gnt1 asserted in the same cycle; the state goes to IDLE (or OWN1 if lock1 = 1).
